// File: rtl/ariane_pkg.sv
// Shared core constants used by the execute-stage units.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;
endpackage

// File: rtl/serdiv_label_wrapper.sv
// Serial radix-2 restoring divider (DIV/DIVU/REM/REMU) with a transaction ID and result label.
// Define SERDIV_LABEL_EN to track operand labels; otherwise res_o_label is tied high.
module serdiv_label_wrapper
  import ariane_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [TRANS_ID_BITS-1:0] id_i,
  input  logic [WIDTH-1:0]         op_a_i,
  input  logic [WIDTH-1:0]         op_b_i,
  input  logic [1:0]               opcode_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [TRANS_ID_BITS-1:0] id_o,
  output logic [WIDTH-1:0]         res_o,
  input  logic                     op_a_i_label,
  input  logic                     op_b_i_label,
  output logic                     res_o_label
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDivide, StFinish} state_e;

  state_e                   state_q;
  logic [WIDTH-1:0]         q_q, b_q, rem_q, res_q;
  logic [CntW-1:0]          cnt_q;
  logic [1:0]               opcode_q;
  logic                     a_sign_q, b_sign_q, out_vld_q;
  logic [TRANS_ID_BITS-1:0] id_q, id_out_q;

  logic             accept, last_step;
  logic             a_neg, b_neg, ge;
  logic [WIDTH-1:0] a_mag, b_mag, q_next, rem_next, q_fix, rem_fix;
  logic [WIDTH:0]   rem_shift, b_ext;

  assign in_rdy_o  = (state_q == StIdle) & ~flush_i;
  assign accept    = in_vld_i & in_rdy_o;
  assign last_step = ~flush_i & (state_q == StDivide) & (cnt_q == '0);

  always_comb begin
    a_neg = opcode_i[0] & op_a_i[WIDTH-1];
    b_neg = opcode_i[0] & op_b_i[WIDTH-1];
    a_mag = a_neg ? -op_a_i : op_a_i;
    b_mag = b_neg ? -op_b_i : op_b_i;

    // One restoring step: shift the next dividend bit into the partial remainder.
    rem_shift = {rem_q, q_q[WIDTH-1]};
    b_ext     = {1'b0, b_q};
    ge        = rem_shift >= b_ext;
    rem_next  = ge ? WIDTH'(rem_shift - b_ext) : rem_shift[WIDTH-1:0];
    q_next    = {q_q[WIDTH-2:0], ge};

    // Division by zero keeps the all-ones quotient unnegated, as RISC-V requires.
    q_fix   = (opcode_q[0] & (a_sign_q ^ b_sign_q) & (b_q != '0)) ? -q_next : q_next;
    rem_fix = (opcode_q[0] & a_sign_q) ? -rem_next : rem_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      q_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      opcode_q  <= '0;
      a_sign_q  <= 1'b0;
      b_sign_q  <= 1'b0;
      out_vld_q <= 1'b0;
      id_q      <= '0;
      id_out_q  <= '0;
    end else if (flush_i) begin
      state_q   <= StIdle;
      out_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opcode_q <= opcode_i;
            id_q     <= id_i;
            q_q      <= a_mag;
            b_q      <= b_mag;
            a_sign_q <= a_neg;
            b_sign_q <= b_neg;
            rem_q    <= '0;
            cnt_q    <= CntW'(WIDTH - 1);
            state_q  <= StDivide;
          end
        end
        StDivide: begin
          q_q   <= q_next;
          rem_q <= rem_next;
          if (cnt_q == '0) begin
            res_q     <= opcode_q[1] ? rem_fix : q_fix;
            id_out_q  <= id_q;
            out_vld_q <= 1'b1;
            state_q   <= StFinish;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFinish: begin
          if (out_rdy_i) begin
            out_vld_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_vld_o = out_vld_q;
  assign res_o     = res_q;
  assign id_o      = id_out_q;

`ifdef SERDIV_LABEL_EN
  logic label_q, res_label_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      label_q     <= 1'b0;
      res_label_q <= 1'b0;
    end else begin
      if (accept) label_q <= op_a_i_label | op_b_i_label;
      if (last_step) res_label_q <= label_q;
    end
  end

  assign res_o_label = res_label_q;
`else
  logic unused_labels;
  assign unused_labels = op_a_i_label ^ op_b_i_label ^ last_step;
  assign res_o_label   = 1'b1;
`endif

endmodule

// File: tb/tb_serdiv_label_wrapper.sv
// Scoreboard bench for serdiv_label_wrapper at WIDTH=8.
module tb_serdiv_label_wrapper;
  import ariane_pkg::*;

  localparam int unsigned W = 8;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic [TRANS_ID_BITS-1:0] id_i;
  logic [W-1:0]             op_a_i, op_b_i;
  logic [1:0]               opcode_i;
  logic                     in_vld_i, in_rdy_o, out_vld_o, out_rdy_i;
  logic [TRANS_ID_BITS-1:0] id_o;
  logic [W-1:0]             res_o;
  logic                     op_a_i_label, op_b_i_label, res_o_label;

  typedef struct packed {
    logic [W-1:0]             res;
    logic [TRANS_ID_BITS-1:0] id;
    logic                     lbl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  serdiv_label_wrapper #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .id_i         (id_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .opcode_i     (opcode_i),
    .in_vld_i     (in_vld_i),
    .in_rdy_o     (in_rdy_o),
    .out_vld_o    (out_vld_o),
    .out_rdy_i    (out_rdy_i),
    .id_o         (id_o),
    .res_o        (res_o),
    .op_a_i_label (op_a_i_label),
    .op_b_i_label (op_b_i_label),
    .res_o_label  (res_o_label)
  );

  function automatic logic exp_label(input logic la, input logic lb);
`ifdef SERDIV_LABEL_EN
    return la | lb;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic reset_label();
`ifdef SERDIV_LABEL_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: RISC-V M-extension semantics at width W.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (op[0]) begin
      if (a == 8'h80 && b == 8'hFF) begin
        q = 8'h80;
        r = '0;
      end else begin
        q = W'($signed(a) / $signed(b));
        r = W'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic la, input logic lb, input logic [TRANS_ID_BITS-1:0] id);
    int n = 0;
    while (!in_rdy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (in_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_rdy: in_rdy_o=%b required 1", in_rdy_o);
    end
    opcode_i     = op;
    op_a_i       = a;
    op_b_i       = b;
    op_a_i_label = la;
    op_b_i_label = lb;
    id_i         = id;
    in_vld_i     = 1'b1;
    sb_q.push_back('{res: model(op, a, b), id: id, lbl: exp_label(la, lb)});
    @(posedge clk_i);
    @(negedge clk_i);
    in_vld_i = 1'b0;
  endtask

  // Edges are counted including the accepting edge; exp_edges==0 skips the latency check.
  task automatic collect(input string name, input int exp_edges);
    int   edges = 1;
    exp_t e;
    while (!out_vld_o && edges < 100) begin
      @(negedge clk_i);
      edges++;
    end
    e = sb_q.pop_front();
    checks++;
    if (out_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_vld_o=%b required 1", name, out_vld_o);
      return;
    end
    if (exp_edges != 0) begin
      checks++;
      if (edges !== exp_edges) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", name, edges, exp_edges);
      end
    end
    checks += 3;
    if (res_o !== e.res) begin
      errors++;
      $display("FAIL %s_res: got %h required %h", name, res_o, e.res);
    end
    if (id_o !== e.id) begin
      errors++;
      $display("FAIL %s_id: got %h required %h", name, id_o, e.id);
    end
    if (res_o_label !== e.lbl) begin
      errors++;
      $display("FAIL %s_label: got %b required %b", name, res_o_label, e.lbl);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (out_vld_o !== 1'b0 || in_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_vld_o=%b in_rdy_o=%b required 0/1", name, out_vld_o,
               in_rdy_o);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0 || res_o !== '0 || id_o !== '0 ||
        res_o_label !== reset_label()) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b res=%h id=%h lbl=%b required 1/0/00/0/%b", name,
               in_rdy_o, out_vld_o, res_o, id_o, res_o_label, reset_label());
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset_state");
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_labels();
    issue(2'd0, 8'h37, 8'h01, 1'b0, 1'b0, 3'd1);
    collect("udiv_37", W + 1);
    issue(2'd0, 8'h3B, 8'h01, 1'b1, 1'b0, 3'd2);
    collect("udiv_3b_la", W + 1);
    issue(2'd0, 8'h3D, 8'h01, 1'b0, 1'b1, 3'd4);
    collect("udiv_3d_lb", W + 1);
  endtask

  task automatic test_signed();
    issue(2'd1, 8'hF9, 8'h02, 1'b0, 1'b0, 3'd5);
    collect("div_f9", 0);
    issue(2'd3, 8'hF9, 8'h02, 1'b1, 1'b0, 3'd6);
    collect("rem_f9", 0);
    issue(2'd0, 8'hF9, 8'h02, 1'b0, 1'b0, 3'd7);
    collect("udiv_f9", 0);
    issue(2'd2, 8'hF9, 8'h02, 1'b0, 1'b1, 3'd0);
    collect("urem_f9", 0);
  endtask

  task automatic test_boundaries();
    issue(2'd0, 8'h2F, 8'h00, 1'b0, 1'b0, 3'd1);
    collect("udiv_by0", 0);
    issue(2'd2, 8'h2F, 8'h00, 1'b0, 1'b0, 3'd2);
    collect("urem_by0", 0);
    issue(2'd1, 8'h80, 8'hFF, 1'b0, 1'b0, 3'd3);
    collect("div_min_m1", 0);
    issue(2'd3, 8'h80, 8'hFF, 1'b0, 1'b0, 3'd4);
    collect("rem_min_m1", 0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    out_rdy_i = 1'b0;
    issue(2'd0, 8'h64, 8'h07, 1'b1, 1'b1, 3'd3);
    while (!out_vld_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_vld_o !== 1'b1 || res_o !== e.res || id_o !== e.id || in_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b res=%h id=%h rdy=%b required 1/%h/%h/0", i,
                 out_vld_o, res_o, id_o, in_rdy_o, e.res, e.id);
      end
      @(negedge clk_i);
    end
    out_rdy_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rdy=%b vld=%b required 1/0", in_rdy_o, out_vld_o);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    issue(2'd0, 8'h55, 8'h03, 1'b0, 1'b0, 3'd5);
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    checks++;
    if (in_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_rdy_low: in_rdy_o=%b required 0", in_rdy_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    checks++;
    if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: rdy=%b vld=%b required 1/0", in_rdy_o, out_vld_o);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (out_vld_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_result: out_vld_o rose=%b required 0", seen);
    end
    issue(2'd0, 8'h3F, 8'h01, 1'b0, 1'b0, 3'd6);
    collect("after_flush", W + 1);
  endtask

  task automatic test_reset_mid();
    issue(2'd1, 8'h9C, 8'h05, 1'b1, 1'b0, 3'd7);
    void'(sb_q.pop_back());
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_reset_values("reset_mid_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_reset_values("reset_mid_release");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 20)),
            1'($urandom), 1'($urandom), 3'($urandom));
      collect("random", W + 1);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    id_i         = '0;
    op_a_i       = '0;
    op_b_i       = '0;
    opcode_i     = '0;
    in_vld_i     = 1'b0;
    out_rdy_i    = 1'b1;
    op_a_i_label = 1'b0;
    op_b_i_label = 1'b0;
    test_reset();
    test_labels();
    test_signed();
    test_boundaries();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
